spi_cmd_controller: RTL and testbench
=====================================

Name: spi_cmd_controller

Overview:
- Command sequencer between the SPI byte-level slave and the motor datapath (pitch/yaw PWM generators, quadrature position counters).
- Decodes the opcode in byte 0 of each CS frame, stages and commits PWM settings, and feeds snapshot position/status bytes back to the slave for POCI.
- Sits inside TopEntity; the only block that writes PWM configuration.

Parameters:
- COUNTER_W, 12, PWM duty width. Legal range 1..14.
- POS_W, 32, encoder position width. Fixed at 32 for the wire format.

Ports:
- clk  in  1  system clock, 25 MHz
- btn1  in  1  synchronous active-high reset
- frame_active  in  1  high while SPI_CS is low; already synchronised to clk
- rx_valid  in  1  one-cycle pulse when a full byte has been received
- rx_byte  in  8  received byte; valid with rx_valid
- tx_byte  out  8  byte the slave shifts out for the next byte slot
- pitch_duty  out  COUNTER_W  pitch PWM duty
- pitch_en  out  1  pitch enable
- pitch_dir  out  1  pitch direction
- yaw_duty  out  COUNTER_W  yaw PWM duty
- yaw_en  out  1  yaw enable
- yaw_dir  out  1  yaw direction
- pitch_pos  in  POS_W  signed pitch position
- yaw_pos  in  POS_W  signed yaw position
- cmd_err  out  1  sticky flag: unknown opcode seen; cleared only by reset

Behaviour:
Reset:
- All PWM outputs are 0, tx_byte = 0x00, cmd_err = 0, and staging registers are cleared.
- If frame_active is high at reset release, go to DISCARD; otherwise go to IDLE.
- A reset mid-frame therefore never commits partial data.

PWM word format (16 bits):
- Bit 15 = en, bit 14 = dir, duty = word[13 -: COUNTER_W]; remaining bits are 0.
- Write payload is little-endian: low byte first, then high byte.
- Read payload is big-endian: high byte first.

Opcodes (byte 0):
- 0x10: write pitch, 2 payload bytes.
- 0x11: write yaw, 2 payload bytes.
- 0x12: write both, 4 bytes (pitch low, pitch high, yaw low, yaw high).
- 0x20: read pitch position, 4 bytes, MSB first.
- 0x21: read yaw position, 4 bytes.
- 0x22: read both, 8 bytes (pitch then yaw).
- 0x30: PWM status, 4 bytes (pitch word then yaw word, big-endian).
- Any other opcode: set cmd_err and go to DISCARD.

FSM:
- IDLE: wait for frame_active rising. Clear byte_idx, set tx_byte = 0x00, go to CMD.
- CMD: on rx_valid, latch the opcode.
  - For read opcodes, snapshot pitch_pos, yaw_pos and the current PWM words in the same cycle, so multi-byte reads are coherent.
  - Then go to WR, RD or DISCARD.
- WR: each rx_valid stores the byte into the staging register.
  - An axis commits (outputs update on the cycle after its high byte's rx_valid) only when both of its bytes have arrived.
  - For 0x12, pitch commits after byte 2 and yaw after byte 4.
  - After the last payload byte, go to DISCARD.
- RD: tx_byte for payload byte n is registered on the rx_valid of byte n-1, i.e. 1 clk after it.
  - The slave samples tx_byte no earlier than 2 clks after rx_valid.
  - After the last byte, go to DISCARD.
- DISCARD: ignore rx_valid. tx_byte = 0x00.
- In any state, frame_active falling returns the FSM to IDLE on the next clk.
  - Uncommitted staging data is dropped.
  - A frame with no bytes clocked has no effect.

Sizes and corner cases:
- byte_idx is 4 bits and saturates at 15. Bytes beyond the payload are ignored and answered with 0x00.
- During byte 0 (opcode slot), tx_byte = 0x00.
- rx_valid coincident with frame_active falling: the byte is processed first, then the FSM goes to IDLE.
- Back-to-back frames with 1 clk of CS high between them must both decode.

Test Plan:
- Reset with btn1 = 1 for 20 clks → all PWM outputs 0, tx_byte = 0x00, cmd_err = 0.
- Frame 12 00 A0 00 D0 → pitch_duty = 0x800, pitch_en = 1, pitch_dir = 0; yaw_duty = 0x400, yaw_en = 1, yaw_dir = 1. Then frame 30 xx xx xx xx → POCI bytes 1..4 = A0 00 D0 00.
- pitch_pos = 492, yaw_pos = -1824, frame 22 + 8 dummy bytes → POCI bytes 1..8 = 00 00 01 EC FF FF F8 E0. Changing pitch_pos mid-frame does not alter the bytes.
- Frame 12 00 A0 00 with CS raised after byte 3 → pitch commits, yaw unchanged. Frame 10 34 with CS raised after byte 1 → pitch unchanged.
- Frame 55 12 00 A0 → cmd_err = 1, no PWM change, POCI all 0x00. A following 0x30 frame still decodes correctly.
- Assert btn1 during byte 2 of a 0x12 frame → outputs 0, DISCARD until CS high. The next 0x11 frame 00 D0 → yaw_duty = 0x400, yaw_en = 1, yaw_dir = 1.

Source files
------------

// File: rtl/spi_cmd_controller_if.sv
// Byte-level link between the SPI slave and the command controller.
// The SPI slave side is the master: it reports frame and byte events
// and shifts out tx_byte for the next byte slot.
interface spi_cmd_controller_if;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  modport master (
    output frame_active,
    output rx_valid,
    output rx_byte,
    input  tx_byte
  );

  modport slave (
    input  frame_active,
    input  rx_valid,
    input  rx_byte,
    output tx_byte
  );
endinterface

// File: rtl/spi_cmd_controller.sv
// Command sequencer between the SPI byte slave and the motor datapath.
// Byte 0 of each CS frame is an opcode; writes stage and commit PWM
// words per axis, reads return a snapshot taken at the opcode byte.
module spi_cmd_controller #(
  parameter int COUNTER_W = 12,
  parameter int POS_W     = 32
) (
  input  logic                        clk,
  input  logic                        btn1,
  spi_cmd_controller_if.slave         spi,
  output logic [COUNTER_W-1:0]        pitch_duty,
  output logic                        pitch_en,
  output logic                        pitch_dir,
  output logic [COUNTER_W-1:0]        yaw_duty,
  output logic                        yaw_en,
  output logic                        yaw_dir,
  input  logic signed [POS_W-1:0]     pitch_pos,
  input  logic signed [POS_W-1:0]     yaw_pos,
  output logic                        cmd_err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_WR      = 3'd2;
  localparam logic [2:0] ST_RD      = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  localparam logic [7:0] OP_WR_PITCH = 8'h10;
  localparam logic [7:0] OP_WR_YAW   = 8'h11;
  localparam logic [7:0] OP_WR_BOTH  = 8'h12;
  localparam logic [7:0] OP_RD_PITCH = 8'h20;
  localparam logic [7:0] OP_RD_YAW   = 8'h21;
  localparam logic [7:0] OP_RD_BOTH  = 8'h22;
  localparam logic [7:0] OP_STATUS   = 8'h30;

  logic [2:0]  state;
  logic [7:0]  opcode;
  logic [3:0]  byte_idx;
  logic [3:0]  next_idx;
  logic [3:0]  rd_len;
  logic [7:0]  stage_lo;
  logic [63:0] snap;
  logic [63:0] rd_data;
  logic [15:0] wr_word;
  logic [3:0]  wr_len;
  logic        wr_to_yaw;

  function automatic logic [15:0] pwm_word(input logic en, input logic dir,
                                           input logic [COUNTER_W-1:0] duty);
    logic [15:0] w;
    w = '0;
    w[15] = en;
    w[14] = dir;
    w[13 -: COUNTER_W] = duty;
    return w;
  endfunction

  // Read payload for the opcode currently on rx_byte, first byte in [63:56]
  always_comb begin
    rd_data = '0;
    case (spi.rx_byte)
      OP_RD_PITCH: rd_data = {pitch_pos, 32'h0};
      OP_RD_YAW:   rd_data = {yaw_pos, 32'h0};
      OP_RD_BOTH:  rd_data = {pitch_pos, yaw_pos};
      OP_STATUS:   rd_data = {pwm_word(pitch_en, pitch_dir, pitch_duty),
                              pwm_word(yaw_en, yaw_dir, yaw_duty), 32'h0};
      default:     rd_data = '0;
    endcase
  end

  // Write-frame decode: a low byte always precedes its high byte, so one
  // staging byte covers both axes of the 0x12 frame
  always_comb begin
    next_idx  = (byte_idx == 4'd15) ? 4'd15 : byte_idx + 4'd1;
    wr_word   = {spi.rx_byte, stage_lo};
    wr_len    = (opcode == OP_WR_BOTH) ? 4'd4 : 4'd2;
    wr_to_yaw = (opcode == OP_WR_YAW) || (opcode == OP_WR_BOTH && byte_idx == 4'd4);
  end

  // Frame sequencer, staging, snapshot and PWM commit
  always_ff @(posedge clk) begin
    if (btn1) begin
      state      <= spi.frame_active ? ST_DISCARD : ST_IDLE;
      opcode     <= '0;
      byte_idx   <= '0;
      rd_len     <= '0;
      stage_lo   <= '0;
      snap       <= '0;
      spi.tx_byte <= '0;
      pitch_duty <= '0;
      pitch_en   <= 1'b0;
      pitch_dir  <= 1'b0;
      yaw_duty   <= '0;
      yaw_en     <= 1'b0;
      yaw_dir    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          byte_idx    <= '0;
          stage_lo    <= '0;
          spi.tx_byte <= '0;
          if (spi.frame_active) state <= ST_CMD;
        end
        ST_CMD: begin
          if (spi.rx_valid) begin
            opcode   <= spi.rx_byte;
            byte_idx <= 4'd1;
            case (spi.rx_byte)
              OP_WR_PITCH, OP_WR_YAW, OP_WR_BOTH: state <= ST_WR;
              OP_RD_PITCH, OP_RD_YAW, OP_RD_BOTH, OP_STATUS: begin
                snap        <= rd_data << 8;
                spi.tx_byte <= rd_data[63:56];
                rd_len      <= (spi.rx_byte == OP_RD_BOTH) ? 4'd8 : 4'd4;
                state       <= ST_RD;
              end
              default: begin
                cmd_err <= 1'b1;
                state   <= ST_DISCARD;
              end
            endcase
          end
        end
        ST_WR: begin
          if (spi.rx_valid) begin
            byte_idx <= next_idx;
            if (byte_idx[0]) begin
              stage_lo <= spi.rx_byte;
            end else if (wr_to_yaw) begin
              yaw_en   <= wr_word[15];
              yaw_dir  <= wr_word[14];
              yaw_duty <= wr_word[13 -: COUNTER_W];
            end else begin
              pitch_en   <= wr_word[15];
              pitch_dir  <= wr_word[14];
              pitch_duty <= wr_word[13 -: COUNTER_W];
            end
            if (byte_idx == wr_len) state <= ST_DISCARD;
          end
        end
        ST_RD: begin
          if (spi.rx_valid) begin
            byte_idx <= next_idx;
            if (byte_idx == rd_len) begin
              spi.tx_byte <= '0;
              state       <= ST_DISCARD;
            end else begin
              spi.tx_byte <= snap[63:56];
              snap        <= snap << 8;
            end
          end
        end
        ST_DISCARD: begin
          spi.tx_byte <= '0;
          if (spi.rx_valid) byte_idx <= next_idx;
        end
        default: state <= ST_IDLE;
      endcase
      // CS release wins over the state update but after any coincident byte
      if (state != ST_IDLE && !spi.frame_active) begin
        state       <= ST_IDLE;
        spi.tx_byte <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller: drives byte-level SPI frames and
// checks committed PWM outputs, POCI bytes and the sticky error flag.
module tb_spi_cmd_controller;
  logic        clk = 1'b0;
  logic        btn1;
  logic [11:0] pitch_duty, yaw_duty;
  logic        pitch_en, pitch_dir, yaw_en, yaw_dir, cmd_err;
  logic signed [31:0] pitch_pos, yaw_pos;
  logic [127:0] miso_p;
  logic [7:0]   p;
  int n_checks = 0;
  int n_fail   = 0;

  spi_cmd_controller_if spi ();

  spi_cmd_controller #(.COUNTER_W(12), .POS_W(32)) dut (
    .clk        (clk),
    .btn1       (btn1),
    .spi        (spi.slave),
    .pitch_duty (pitch_duty),
    .pitch_en   (pitch_en),
    .pitch_dir  (pitch_dir),
    .yaw_duty   (yaw_duty),
    .yaw_en     (yaw_en),
    .yaw_dir    (yaw_dir),
    .pitch_pos  (pitch_pos),
    .yaw_pos    (yaw_pos),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One byte slot: sample POCI, then pulse rx_valid with the MOSI byte
  task automatic xfer(input logic [7:0] b, output logic [7:0] poci);
    repeat (2) @(negedge clk);
    poci = spi.tx_byte;
    spi.rx_byte  = b;
    spi.rx_valid = 1'b1;
    @(negedge clk);
    spi.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Full frame, first byte in the most significant occupied byte of 'bytes'
  task automatic run_frame(input logic [127:0] bytes, input int n, input int gap);
    logic [7:0] q;
    spi.frame_active = 1'b1;
    miso_p = '0;
    for (int i = 0; i < n; i++) begin
      xfer(bytes[8*(n-1-i) +: 8], q);
      miso_p = {miso_p[119:0], q};
    end
    spi.frame_active = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_pitch(input string tag, input logic [11:0] d, input logic en, input logic dir);
    check_eq({tag, "_pitch"}, {pitch_duty, pitch_en, pitch_dir}, {d, en, dir});
  endtask

  task automatic check_yaw(input string tag, input logic [11:0] d, input logic en, input logic dir);
    check_eq({tag, "_yaw"}, {yaw_duty, yaw_en, yaw_dir}, {d, en, dir});
  endtask

  initial begin
    btn1 = 1'b1;
    spi.frame_active = 1'b0;
    spi.rx_valid = 1'b0;
    spi.rx_byte = 8'h00;
    pitch_pos = 32'sd0;
    yaw_pos = 32'sd0;
    repeat (20) @(negedge clk);
    btn1 = 1'b0;
    @(negedge clk);
    check_pitch("reset", 12'h000, 1'b0, 1'b0);
    check_yaw("reset", 12'h000, 1'b0, 1'b0);
    check_eq("reset_tx", spi.tx_byte, 8'h00);
    check_eq("reset_err", cmd_err, 1'b0);

    // Write both axes
    run_frame(40'h1200A000D0, 5, 2);
    check_pitch("wr_both", 12'h800, 1'b1, 1'b0);
    check_yaw("wr_both", 12'h400, 1'b1, 1'b1);
    check_eq("wr_both_poci", miso_p, 40'h0);

    // PWM status readback, big-endian words
    run_frame(40'h3000000000, 5, 2);
    check_eq("status1_poci", miso_p, 40'h00A000D000);

    // Last byte's rx_valid coincident with CS release still commits
    spi.frame_active = 1'b1;
    xfer(8'h10, p);
    xfer(8'h08, p);
    repeat (2) @(negedge clk);
    spi.rx_byte = 8'h70;
    spi.rx_valid = 1'b1;
    spi.frame_active = 1'b0;
    @(negedge clk);
    spi.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_pitch("coincident", 12'hC02, 1'b0, 1'b1);

    // Back-to-back frames with one clock of CS high
    run_frame(24'h1004B0, 3, 1);
    run_frame(40'h3000000000, 5, 2);
    check_pitch("b2b", 12'hC01, 1'b1, 1'b0);
    check_eq("b2b_status_poci", miso_p, 40'h00B004D000);

    // Coherent position snapshot; pitch_pos changes after the opcode
    pitch_pos = 32'sd492;
    yaw_pos = -32'sd1824;
    spi.frame_active = 1'b1;
    miso_p = '0;
    xfer(8'h22, p);
    miso_p = {miso_p[119:0], p};
    pitch_pos = 32'sh12345678;
    for (int i = 0; i < 8; i++) begin
      xfer(8'h00, p);
      miso_p = {miso_p[119:0], p};
    end
    spi.frame_active = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rd_both_poci", miso_p, 72'h00000001ECFFFFF8E0);

    // Single-axis read, extra bytes beyond payload answer 0x00
    run_frame(56'h21000000000000, 7, 2);
    check_eq("rd_yaw_poci", miso_p, 56'h00FFFFF8E00000);

    // CS raised after byte 3 of 0x12: pitch commits, yaw stays
    run_frame(32'h1200A000, 4, 2);
    check_pitch("partial12", 12'h800, 1'b1, 1'b0);
    check_yaw("partial12", 12'h400, 1'b1, 1'b1);

    // CS raised after byte 1 of 0x10: pitch unchanged
    run_frame(16'h1034, 2, 2);
    check_pitch("partial10", 12'h800, 1'b1, 1'b0);

    // Unknown opcode
    run_frame(32'h551200A0, 4, 2);
    check_eq("bad_op_err", cmd_err, 1'b1);
    check_pitch("bad_op", 12'h800, 1'b1, 1'b0);
    check_eq("bad_op_poci", miso_p, 32'h0);
    run_frame(40'h3000000000, 5, 2);
    check_eq("status2_poci", miso_p, 40'h00A000D000);
    check_eq("err_sticky", cmd_err, 1'b1);

    // Reset during byte 2 of a 0x12 frame
    spi.frame_active = 1'b1;
    xfer(8'h12, p);
    xfer(8'h00, p);
    btn1 = 1'b1;
    repeat (3) @(negedge clk);
    btn1 = 1'b0;
    @(negedge clk);
    check_pitch("midreset", 12'h000, 1'b0, 1'b0);
    check_yaw("midreset", 12'h000, 1'b0, 1'b0);
    check_eq("midreset_err", cmd_err, 1'b0);
    xfer(8'hA0, p);
    check_eq("discard_tx", p, 8'h00);
    xfer(8'h00, p);
    xfer(8'hD0, p);
    spi.frame_active = 1'b0;
    repeat (2) @(negedge clk);
    check_pitch("after_discard", 12'h000, 1'b0, 1'b0);
    check_yaw("after_discard", 12'h000, 1'b0, 1'b0);

    run_frame(24'h1100D0, 3, 2);
    check_yaw("wr_yaw", 12'h400, 1'b1, 1'b1);
    check_pitch("wr_yaw", 12'h000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
